// File: rtl/ysyx_23060072_pipe_ctrl.sv
// Pipeline controller for the RV32E 2-stage core: sequences redirects, LSU/muldiv
// stalls and deferred redirects, and keeps redirect/stall performance counters.
//
// state  | meaning
// RUN    | normal issue; redirects accepted when not stalled
// FLUSH  | ID/EX squashed for FLUSH_CYCLES after a redirect
// MULDIV | waiting for a multi-cycle mul/div result (bounded by timeout)
module ysyx_23060072_pipe_ctrl #(
  parameter int FLUSH_CYCLES   = 1,
  parameter int MULDIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_req_i,
  input  logic [31:0] jump_pc_i,
  input  logic        mem_stall_i,
  input  logic        muldiv_start_i,
  input  logic        muldiv_done_i,
  output logic        if_hold_flag_o,
  output logic        clean_flag_o,
  output logic [31:0] jump_pc_o,
  output logic        ex_flush_o,
  output logic        muldiv_err_o,
  output logic [31:0] redirect_cnt_o,
  output logic [31:0] stall_cnt_o
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TW = $clog2(MULDIV_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    MULDIV = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] flush_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          pending;
  logic [31:0]   pending_pc;

  logic in_run, muldiv_go, stall;
  logic issue_pending, issue_new, issue, latch_pending;
  logic tmo_last, tmo_hit, flush_last;

  // A jump in the same cycle, or an outstanding deferred jump, makes the
  // muldiv instruction wrong-path, so it never starts.
  assign in_run        = (state == RUN);
  assign muldiv_go     = in_run & muldiv_start_i & ~jump_req_i & ~pending;
  assign stall         = mem_stall_i | (state == MULDIV) | muldiv_go;
  assign issue_pending = in_run & ~stall & pending;
  assign issue_new     = in_run & ~stall & ~pending & jump_req_i;
  assign issue         = issue_pending | issue_new;
  assign latch_pending = jump_req_i & stall & ~pending & (state != FLUSH);
  assign tmo_last      = (tmo_cnt == TW'(MULDIV_TIMEOUT - 1));
  assign tmo_hit       = (state == MULDIV) & ~muldiv_done_i & tmo_last;
  assign flush_last    = (flush_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      flush_cnt      <= '0;
      tmo_cnt        <= '0;
      pending        <= 1'b0;
      pending_pc     <= '0;
      clean_flag_o   <= 1'b0;
      jump_pc_o      <= '0;
      muldiv_err_o   <= 1'b0;
      redirect_cnt_o <= '0;
      stall_cnt_o    <= '0;
    end else begin
      state        <= state_nxt;
      clean_flag_o <= issue;
      muldiv_err_o <= tmo_hit;

      if (issue)
        flush_cnt <= FW'(FLUSH_CYCLES - 1);
      else if (state == FLUSH && !flush_last)
        flush_cnt <= flush_cnt - 1'b1;

      if (muldiv_go)
        tmo_cnt <= '0;
      else if (state == MULDIV)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (issue_pending) begin
        pending <= 1'b0;
      end else if (latch_pending) begin
        pending    <= 1'b1;
        pending_pc <= jump_pc_i;
      end

      if (issue)
        jump_pc_o <= issue_pending ? pending_pc : jump_pc_i;

      if (clean_flag_o)
        redirect_cnt_o <= redirect_cnt_o + 32'd1;
      if (if_hold_flag_o)
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (issue)
          state_nxt = FLUSH;
        else if (muldiv_go)
          state_nxt = MULDIV;
      end
      FLUSH: begin
        if (flush_last)
          state_nxt = RUN;
      end
      MULDIV: begin
        if (muldiv_done_i || tmo_last)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // A redirect in flight overrides hold so IF can load the new PC.
  always_comb begin
    if_hold_flag_o = stall & ~clean_flag_o & ~rst;
    ex_flush_o     = (state == FLUSH);
  end

endmodule

// File: tb/tb_ysyx_23060072_pipe_ctrl.sv
// Scoreboard bench for ysyx_23060072_pipe_ctrl: a cycle model predicts every
// output; a negedge monitor pops predictions and compares them.
module tb_ysyx_23060072_pipe_ctrl;
  localparam int FC = 2;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst, jump_req_i, mem_stall_i, muldiv_start_i, muldiv_done_i;
  logic [31:0] jump_pc_i;
  logic        if_hold_flag_o, clean_flag_o, ex_flush_o, muldiv_err_o;
  logic [31:0] jump_pc_o, redirect_cnt_o, stall_cnt_o;

  ysyx_23060072_pipe_ctrl #(.FLUSH_CYCLES(FC), .MULDIV_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .jump_req_i(jump_req_i), .jump_pc_i(jump_pc_i),
    .mem_stall_i(mem_stall_i), .muldiv_start_i(muldiv_start_i),
    .muldiv_done_i(muldiv_done_i),
    .if_hold_flag_o(if_hold_flag_o), .clean_flag_o(clean_flag_o),
    .jump_pc_o(jump_pc_o), .ex_flush_o(ex_flush_o),
    .muldiv_err_o(muldiv_err_o), .redirect_cnt_o(redirect_cnt_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hold, clean, flush, err;
    logic [31:0] jpc, rc, sc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // model state: what the registered outputs and sequencing look like this cycle
  int          flush_left;
  int          md_age;      // -1 when no mul/div in flight
  bit          pend;
  logic [31:0] pend_pc;
  bit          m_clean, m_err;
  logic [31:0] m_jpc, m_rc, m_sc;

  task automatic model_reset();
    flush_left = 0; md_age = -1; pend = 0; pend_pc = '0;
    m_clean = 0; m_err = 0; m_jpc = '0; m_rc = '0; m_sc = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit jr, input logic [31:0] pc,
                      input bit ms, input bit st, input bit dn);
    bit   in_md, in_fl, in_run, go, stl, hold, iss;
    logic [31:0] tgt;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; jump_req_i = jr; jump_pc_i = pc;
    mem_stall_i = ms; muldiv_start_i = st; muldiv_done_i = dn;
    if (r) begin
      model_reset();
      return;
    end
    in_md  = (md_age >= 0);
    in_fl  = (flush_left > 0);
    in_run = !in_md && !in_fl;
    go     = in_run && st && !jr && !pend;
    stl    = ms || in_md || go;
    hold   = stl && !m_clean;
    e.hold = hold; e.clean = m_clean; e.flush = in_fl; e.err = m_err;
    e.jpc = m_jpc; e.rc = m_rc; e.sc = m_sc;
    q.push_back(e);

    m_rc = m_rc + (m_clean ? 32'd1 : 32'd0);
    m_sc = m_sc + (hold ? 32'd1 : 32'd0);
    iss = 0; tgt = '0;
    if (in_run && !stl && pend) begin
      iss = 1; tgt = pend_pc; pend = 0;
    end else if (in_run && !stl && jr) begin
      iss = 1; tgt = pc;
    end else if (jr && stl && !pend && !in_fl) begin
      pend = 1; pend_pc = pc;
    end
    m_clean = iss;
    if (iss) m_jpc = tgt;
    m_err = 0;
    if (iss) flush_left = FC;
    else if (in_fl) flush_left--;
    if (in_md) begin
      if (dn) md_age = -1;
      else if (md_age == TO - 1) begin md_age = -1; m_err = 1; end
      else md_age++;
    end
    if (go) md_age = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hold", {31'b0, if_hold_flag_o}, {31'b0, e.hold});
        chk("clean", {31'b0, clean_flag_o}, {31'b0, e.clean});
        chk("ex_flush", {31'b0, ex_flush_o}, {31'b0, e.flush});
        chk("muldiv_err", {31'b0, muldiv_err_o}, {31'b0, e.err});
        chk("jump_pc", jump_pc_o, e.jpc);
        chk("redirect_cnt", redirect_cnt_o, e.rc);
        chk("stall_cnt", stall_cnt_o, e.sc);
      end
    end
  end

  initial begin : stim
    int wait_cyc;
    rst = 1; jump_req_i = 0; jump_pc_i = '0;
    mem_stall_i = 0; muldiv_start_i = 0; muldiv_done_i = 0;
    model_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(2);
    // redirect, then a wrong-path jump during FLUSH
    step(0, 1, 32'h8000_0100, 0, 0, 0);
    step(0, 1, 32'hdead_beef, 0, 0, 0);
    idle(3);
    // jump deferred behind an LSU stall
    step(0, 0, 32'h0, 1, 0, 0);
    step(0, 1, 32'h0000_0040, 1, 0, 0);
    step(0, 0, 32'h0, 1, 0, 0);
    idle(4);
    // muldiv completing normally
    step(0, 0, 32'h0, 0, 1, 0);
    idle(4);
    step(0, 0, 32'h0, 0, 0, 1);
    idle(2);
    // muldiv timeout
    step(0, 0, 32'h0, 0, 1, 0);
    idle(12);
    // jump and muldiv start together: redirect wins
    step(0, 1, 32'h0000_0200, 0, 1, 0);
    idle(3);
    // pending redirect dropped by reset
    step(0, 0, 32'h0, 0, 1, 0);
    step(0, 1, 32'h0000_0123, 0, 0, 0);
    step(0, 1, 32'h0000_0456, 0, 0, 0);
    step(1, 0, 32'h0, 0, 0, 0);
    idle(6);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 5) == 0),
           $urandom(),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0));
    end
    idle(2);
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
